// File: rtl/openofdm_tx_bit_gen_pkg.sv
// Shared constants for the legacy TX DATA-field bit generator: rate codes,
// N_DBPS lookup, field lengths, scrambler taps and FSM state encoding.
package openofdm_tx_bit_gen_pkg;

  localparam logic [3:0] Rate6M  = 4'b1011;
  localparam logic [3:0] Rate9M  = 4'b1111;
  localparam logic [3:0] Rate12M = 4'b1010;
  localparam logic [3:0] Rate18M = 4'b1110;
  localparam logic [3:0] Rate24M = 4'b1001;
  localparam logic [3:0] Rate36M = 4'b1101;
  localparam logic [3:0] Rate48M = 4'b1000;
  localparam logic [3:0] Rate54M = 4'b1100;

  localparam int unsigned ServiceBits = 16;
  localparam int unsigned TailBits    = 6;

  // x^7 + x^4 + 1 scrambler: feedback from state bits 6 and 3
  localparam int unsigned ScramTapHi   = 6;
  localparam int unsigned ScramTapLo   = 3;
  localparam logic [6:0]  ScramDefault = 7'h7F;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCalc    = 3'd1;
  localparam logic [2:0] StService = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StTail    = 3'd4;
  localparam logic [2:0] StPad     = 3'd5;

  // Data bits per OFDM symbol; 0 flags an invalid rate code
  function automatic logic [7:0] n_dbps_lookup(input logic [3:0] rate);
    case (rate)
      Rate6M:  return 8'd24;
      Rate9M:  return 8'd36;
      Rate12M: return 8'd48;
      Rate18M: return 8'd72;
      Rate24M: return 8'd96;
      Rate36M: return 8'd144;
      Rate48M: return 8'd192;
      Rate54M: return 8'd216;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/openofdm_tx_bit_gen_if.sv
// PSDU byte stream in and scrambled bit stream out of the TX bit generator.
// The slave modport is the bit generator, the master modport its environment.
interface openofdm_tx_bit_gen_if;
  logic [7:0] byte_in;
  logic       byte_in_valid;
  logic       byte_in_ready;
  logic       bit_out;
  logic       bit_out_valid;
  logic       bit_out_ready;
  logic       bit_out_last;

  modport master (
    output byte_in, byte_in_valid, bit_out_ready,
    input  byte_in_ready, bit_out, bit_out_valid, bit_out_last
  );

  modport slave (
    input  byte_in, byte_in_valid, bit_out_ready,
    output byte_in_ready, bit_out, bit_out_valid, bit_out_last
  );
endinterface

// File: rtl/openofdm_tx_bit_gen_scrambler.sv
// 802.11 frame-synchronous scrambler; output is combinational on the current
// state, state advances only when en_i marks a consumed bit.
module openofdm_tx_bit_gen_scrambler
  import openofdm_tx_bit_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [6:0] seed_i,
  input  logic       en_i,
  input  logic       data_i,
  input  logic       force_zero_i,
  output logic       data_o
);

  logic [6:0] state_q, state_d;
  logic       fb;

  assign fb     = state_q[ScramTapHi] ^ state_q[ScramTapLo];
  assign data_o = force_zero_i ? 1'b0 : (data_i ^ fb);

  // Seed load wins over advance; an all-zero seed would lock up, so use 7F
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 7'd0) ? ScramDefault : seed_i;
    end else if (en_i) begin
      state_d = {state_q[5:0], fb};
    end
  end

  // Scrambler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ScramDefault;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/openofdm_tx_bit_gen.sv
// Legacy 802.11a/g DATA-field bit generator: SERVICE, PSDU (LSB first), tail
// and pad bits, scrambled, one bit per valid/ready transfer.
module openofdm_tx_bit_gen
  import openofdm_tx_bit_gen_pkg::*;
#(
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned NSYM_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [3:0]            rate_i,
  input  logic [LEN_WIDTH-1:0]  psdu_len_i,
  input  logic [6:0]            scram_seed_i,
  openofdm_tx_bit_gen_if.slave  bus,
  output logic                  busy_o,
  output logic                  rate_err_o,
  output logic [NSYM_WIDTH-1:0] n_ofdm_sym_o,
  output logic [8:0]            n_pad_bits_o,
  output logic                  phy_len_valid_o
);

  logic [2:0]            state_q, state_d;
  logic [7:0]            n_dbps_q, n_dbps_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic signed [17:0]    rem_q, rem_d;
  logic [NSYM_WIDTH-1:0] n_sym_q, n_sym_d, n_ofdm_sym_q, n_ofdm_sym_d;
  logic [8:0]            n_pad_q, n_pad_d;
  logic                  plv_q, plv_d, rate_err_q, rate_err_d;
  logic [7:0]            cnt_q, cnt_d, byte_q, byte_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  full_q, full_d;

  logic [7:0] rate_ndbps;
  logic       out_valid, xfer, drain, byte_acc, data_bit, scr_out, scr_load;

  assign rate_ndbps = n_dbps_lookup(rate_i);
  assign out_valid  = (state_q == StService) || (state_q == StTail) || (state_q == StPad) ||
                      ((state_q == StData) && full_q);
  assign xfer       = out_valid && bus.bit_out_ready;
  assign drain      = (state_q == StData) && xfer && (bit_idx_q == 3'd7);
  // Refill in the same cycle the last bit drains so DATA has no bubble
  assign bus.byte_in_ready = (state_q == StData) && (byte_cnt_q != len_q) && (!full_q || drain);
  assign byte_acc   = bus.byte_in_valid && bus.byte_in_ready;
  assign data_bit   = (state_q == StData) ? byte_q[bit_idx_q] : 1'b0;

  assign bus.bit_out       = out_valid && scr_out;
  assign bus.bit_out_valid = out_valid;
  assign bus.bit_out_last  =
      ((state_q == StPad) && ({1'b0, cnt_q} == n_pad_q - 9'd1)) ||
      ((state_q == StTail) && (cnt_q == 8'(TailBits - 1)) && (n_pad_q == 9'd0));

  assign busy_o          = (state_q != StIdle);
  assign rate_err_o      = rate_err_q;
  assign n_ofdm_sym_o    = n_ofdm_sym_q;
  assign n_pad_bits_o    = n_pad_q;
  assign phy_len_valid_o = plv_q;

  openofdm_tx_bit_gen_scrambler u_scrambler (
    .clk          (clk),
    .rst          (rst),
    .load_i       (scr_load),
    .seed_i       (scram_seed_i),
    .en_i         (xfer),
    .data_i       (data_bit),
    .force_zero_i (state_q == StTail),
    .data_o       (scr_out)
  );

  // Frame sequencing, symbol-count division and byte buffering
  always_comb begin
    state_d      = state_q;
    n_dbps_d     = n_dbps_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    rem_d        = rem_q;
    n_sym_d      = n_sym_q;
    n_ofdm_sym_d = n_ofdm_sym_q;
    n_pad_d      = n_pad_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    bit_idx_d    = bit_idx_q;
    full_d       = full_q;
    plv_d        = 1'b0;
    rate_err_d   = 1'b0;
    scr_load     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (rate_ndbps != 8'd0) begin
            n_dbps_d   = rate_ndbps;
            len_d      = psdu_len_i;
            rem_d      = $signed(18'({psdu_len_i, 3'b000}) + 18'd22);
            n_sym_d    = '0;
            cnt_d      = '0;
            bit_idx_d  = '0;
            byte_cnt_d = '0;
            full_d     = 1'b0;
            scr_load   = 1'b1;
            state_d    = StCalc;
          end else begin
            rate_err_d = 1'b1;
          end
        end
      end
      StCalc: begin
        if (rem_q > 18'sd0) begin
          rem_d   = rem_q - $signed({10'd0, n_dbps_q});
          n_sym_d = n_sym_q + NSYM_WIDTH'(1);
        end else begin
          n_pad_d      = 9'(-rem_q);
          n_ofdm_sym_d = n_sym_q;
          plv_d        = 1'b1;
          state_d      = StService;
        end
      end
      StService: begin
        if (xfer) begin
          if (cnt_q == 8'(ServiceBits - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? StTail : StData;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StData: begin
        if (xfer) bit_idx_d = bit_idx_q + 3'd1;
        if (byte_acc) begin
          byte_d     = bus.byte_in;
          full_d     = 1'b1;
          byte_cnt_d = byte_cnt_q + LEN_WIDTH'(1);
        end else if (drain) begin
          full_d = 1'b0;
          if (byte_cnt_q == len_q) state_d = StTail;
        end
      end
      StTail: begin
        if (xfer) begin
          if (cnt_q == 8'(TailBits - 1)) begin
            cnt_d   = '0;
            state_d = (n_pad_q == 9'd0) ? StIdle : StPad;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StPad: begin
        if (xfer) begin
          if ({1'b0, cnt_q} == n_pad_q - 9'd1) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      n_dbps_q     <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      rem_q        <= '0;
      n_sym_q      <= '0;
      n_ofdm_sym_q <= '0;
      n_pad_q      <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      bit_idx_q    <= '0;
      full_q       <= 1'b0;
      plv_q        <= 1'b0;
      rate_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_dbps_q     <= n_dbps_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      rem_q        <= rem_d;
      n_sym_q      <= n_sym_d;
      n_ofdm_sym_q <= n_ofdm_sym_d;
      n_pad_q      <= n_pad_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      bit_idx_q    <= bit_idx_d;
      full_q       <= full_d;
      plv_q        <= plv_d;
      rate_err_q   <= rate_err_d;
    end
  end

endmodule
